// File: rtl/temp_sensor_responder.sv
// temp_sensor_responder: averages 2**AVG_LOG2 ADC samples per read request and answers with {valid, data} after a fixed conversion delay
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   rd_req            one-cycle read request from the controller
//   sensor_en         enable; low ignores requests and aborts any read in flight
//   raw_temp[7:0]     ADC sample, taken once per cycle while sampling
//   dout[8:0]         {valid, averaged temperature}; all zero unless responding
//   busy              high whenever a read is in flight
//   overrun_cnt[7:0]  saturating count of requests dropped while busy
module temp_sensor_responder #(
  parameter int CONV_CYCLES = 3,
  parameter int AVG_LOG2    = 2,
  parameter int RESP_HOLD   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic       sensor_en,
  input  logic [7:0] raw_temp,
  output logic [8:0] dout,
  output logic       busy,
  output logic [7:0] overrun_cnt
);
  localparam int AW = 8 + AVG_LOG2;
  localparam logic [3:0] S_LAST = 4'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] C_LAST = 4'(CONV_CYCLES - 1);
  localparam logic [3:0] H_LAST = 4'(RESP_HOLD - 1);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, RESPOND} state_t;
  state_t state_q;
  logic [AW-1:0] acc_q, acc_d;
  logic [3:0] cnt_q;
  logic [7:0] res_q, ovr_q;
  logic [8:0] dout_q;
  // Sum including this cycle's sample, so the final average is ready on the last sample edge.
  assign acc_d = acc_q + AW'(raw_temp);
  assign dout = dout_q;
  assign busy = state_q != IDLE;
  assign overrun_cnt = ovr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ovr_q <= '0;
      dout_q <= '0;
    end else begin
      if (rd_req && state_q != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
      if (state_q != IDLE && !sensor_en) begin
        state_q <= IDLE;
        acc_q <= '0;
        cnt_q <= '0;
        dout_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (rd_req && sensor_en) begin
            state_q <= SAMPLE;
            acc_q <= '0;
            cnt_q <= '0;
          end
          SAMPLE: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == S_LAST) begin
              res_q <= acc_d[AW-1:AVG_LOG2];
              state_q <= CONVERT;
              cnt_q <= '0;
            end
          end
          CONVERT: begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == C_LAST) begin
              state_q <= RESPOND;
              dout_q <= {1'b1, res_q};
              cnt_q <= '0;
            end
          end
          RESPOND: begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == H_LAST) begin
              state_q <= IDLE;
              dout_q <= '0;
              cnt_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
